// File: rtl/tm1638_pkg.sv
// Shared types and constants for the TM1638 responder.
// Optional build macro used by the top: TM1638_KEY_SNAPSHOT_EN.
package tm1638_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WR_DATA,
        S_RD_DATA,
        S_IGNORE
    } state_t;

    // Command class, taken from bits [7:6] of the first byte after strobe falls.
    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_CTRL = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    // Bit positions inside the command byte.
    localparam int BIT_READ    = 1;
    localparam int BIT_FIXED   = 2;
    localparam int BIT_DISP_ON = 3;

    function automatic logic [1:0] cmd_class(input logic [7:0] cmd);
        return cmd[7:6];
    endfunction

endpackage

// File: rtl/tm1638_bus_sync.sv
// Synchronizes the STB/CLK/DIO pins into clk and produces single-cycle
// edge strobes on the synchronized sck and cs. Flops reset to 1 so that
// an idle bus (sck and cs high) produces no edge when reset releases.
module tm1638_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sck,
    input  logic cs,
    input  logic dio_i,
    output logic cs_s,
    output logic dio_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall
);

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] dio_sync_q;
    logic                   sck_prev_q;
    logic                   cs_prev_q;
    logic                   sck_s;

    // Synchronizer chains plus one delayed copy of sck/cs for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync_q <= '1;
            cs_sync_q  <= '1;
            dio_sync_q <= '1;
            sck_prev_q <= 1'b1;
            cs_prev_q  <= 1'b1;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            dio_sync_q <= {dio_sync_q[SYNC_STAGES-2:0], dio_i};
            sck_prev_q <= sck_s;
            cs_prev_q  <= cs_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign dio_s    = dio_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;

endmodule

// File: rtl/tm1638_responder.sv
// Peripheral-side TM1638 model on the 3-wire STB/CLK/DIO bus (LSB first).
// Build macro TM1638_KEY_SNAPSHOT_EN: when defined, key_data is latched in
// full when a read command is accepted; otherwise each key byte is sampled
// live at the falling edge that drives its bit 0.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | strobe high, waiting for cs to fall
//   S_CMD     | shifting in the command byte
//   S_WR_DATA | each complete byte is written to display RAM
//   S_RD_DATA | driving key-scan bits on sck falling edges
//   S_IGNORE  | discarding bits until cs rises
module tm1638_responder
    import tm1638_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RAM_BYTES   = 16,
    parameter int KEY_BYTES   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sck,
    input  logic                          cs,
    input  logic                          dio_i,
    output logic                          dio_o,
    output logic                          dio_e,
    output logic [RAM_BYTES-1:0][7:0]     display_ram,
    output logic                          display_on,
    output logic [2:0]                    brightness,
    input  logic [KEY_BYTES-1:0][7:0]     key_data,
    output logic                          ram_wr,
    output logic [$clog2(RAM_BYTES)-1:0]  ram_wr_addr,
    output logic                          key_rd
);

    localparam int AW    = $clog2(RAM_BYTES);
    localparam int KBITS = KEY_BYTES * 8;
    localparam int KW    = $clog2(KBITS);
    localparam logic [KW-1:0] LAST_BIT = KW'(KBITS - 1);

    logic cs_s, dio_s, sck_rise, sck_fall, cs_rise, cs_fall;

    tm1638_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .cs       (cs),
        .dio_i    (dio_i),
        .cs_s     (cs_s),
        .dio_s    (dio_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall)
    );

    state_t                     state_q, state_d;
    logic [2:0]                 bit_cnt_q, bit_cnt_d;
    logic [7:0]                 shift_q, shift_d;
    logic [AW-1:0]              addr_q, addr_d;
    logic                       fixed_q, fixed_d;
    logic                       on_q, on_d;
    logic [2:0]                 bright_q, bright_d;
    logic                       dio_o_q, dio_o_d;
    logic                       dio_e_q, dio_e_d;
    logic [KW-1:0]              rd_cnt_q, rd_cnt_d;
    logic                       ram_wr_q, ram_wr_d;
    logic [AW-1:0]              ram_wr_addr_q, ram_wr_addr_d;
    logic                       key_rd_q, key_rd_d;
    logic [RAM_BYTES-1:0][7:0]  display_ram_q;
    logic [7:0]                 wr_data;
    logic [7:0]                 byte_in;
`ifdef TM1638_KEY_SNAPSHOT_EN
    logic [KBITS-1:0]           snap_q, snap_d;
`else
    logic [7:0]                 key_byte_q, key_byte_d;
`endif

    // LSB first: new bit enters at the top, so after 8 shifts bit 0 is the first bit.
    assign byte_in = {dio_s, shift_q[7:1]};

    // Next-state and output decode; cs edges take priority over any sck edge.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        addr_d        = addr_q;
        fixed_d       = fixed_q;
        on_d          = on_q;
        bright_d      = bright_q;
        dio_o_d       = dio_o_q;
        dio_e_d       = dio_e_q;
        rd_cnt_d      = rd_cnt_q;
        ram_wr_d      = 1'b0;
        ram_wr_addr_d = ram_wr_addr_q;
        key_rd_d      = 1'b0;
        wr_data       = 8'h00;
`ifdef TM1638_KEY_SNAPSHOT_EN
        snap_d        = snap_q;
`else
        key_byte_d    = key_byte_q;
`endif

        if (cs_rise) begin
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            dio_e_d   = 1'b0;
            dio_o_d   = 1'b1;
        end else if (cs_fall) begin
            state_d   = S_CMD;
            bit_cnt_d = 3'd0;
        end else if (!cs_s) begin
            if (sck_rise && (state_q == S_CMD || state_q == S_WR_DATA)) begin
                shift_d   = byte_in;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (state_q == S_CMD) begin
                        case (cmd_class(byte_in))
                            CMD_DATA: begin
                                fixed_d = byte_in[BIT_FIXED];
                                if (byte_in[BIT_READ]) begin
                                    state_d  = S_RD_DATA;
                                    key_rd_d = 1'b1;
                                    rd_cnt_d = '0;
`ifdef TM1638_KEY_SNAPSHOT_EN
                                    snap_d   = key_data;
`endif
                                end else begin
                                    state_d = S_IGNORE;
                                end
                            end
                            CMD_ADDR: begin
                                addr_d  = AW'(byte_in[3:0]);
                                state_d = S_WR_DATA;
                            end
                            CMD_CTRL: begin
                                on_d     = byte_in[BIT_DISP_ON];
                                bright_d = byte_in[2:0];
                                state_d  = S_IGNORE;
                            end
                            default: state_d = S_IGNORE;
                        endcase
                    end else begin
                        ram_wr_d      = 1'b1;
                        ram_wr_addr_d = addr_q;
                        wr_data       = byte_in;
                        if (!fixed_q) begin
                            addr_d = addr_q + AW'(1);
                        end
                    end
                end
            end

            if (state_q == S_RD_DATA) begin
                if (sck_fall) begin
                    dio_e_d = 1'b1;
`ifdef TM1638_KEY_SNAPSHOT_EN
                    dio_o_d = snap_q[rd_cnt_q];
`else
                    if (rd_cnt_q[2:0] == 3'd0) begin
                        key_byte_d = key_data[rd_cnt_q[KW-1:3]];
                        dio_o_d    = key_data[rd_cnt_q[KW-1:3]][0];
                    end else begin
                        dio_o_d    = key_byte_q[rd_cnt_q[2:0]];
                    end
`endif
                end else if (sck_rise && dio_e_q) begin
                    // The controller has just sampled bit rd_cnt_q.
                    if (rd_cnt_q == LAST_BIT) begin
                        dio_e_d = 1'b0;
                        dio_o_d = 1'b1;
                        state_d = S_IGNORE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + KW'(1);
                    end
                end
            end
        end
    end

    // State, mode/address, display RAM and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            addr_q        <= '0;
            fixed_q       <= 1'b0;
            on_q          <= 1'b0;
            bright_q      <= 3'd0;
            dio_o_q       <= 1'b1;
            dio_e_q       <= 1'b0;
            rd_cnt_q      <= '0;
            ram_wr_q      <= 1'b0;
            ram_wr_addr_q <= '0;
            key_rd_q      <= 1'b0;
            display_ram_q <= '0;
`ifdef TM1638_KEY_SNAPSHOT_EN
            snap_q        <= '0;
`else
            key_byte_q    <= 8'h00;
`endif
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            addr_q        <= addr_d;
            fixed_q       <= fixed_d;
            on_q          <= on_d;
            bright_q      <= bright_d;
            dio_o_q       <= dio_o_d;
            dio_e_q       <= dio_e_d;
            rd_cnt_q      <= rd_cnt_d;
            ram_wr_q      <= ram_wr_d;
            ram_wr_addr_q <= ram_wr_addr_d;
            key_rd_q      <= key_rd_d;
            if (ram_wr_d) begin
                display_ram_q[ram_wr_addr_d] <= wr_data;
            end
`ifdef TM1638_KEY_SNAPSHOT_EN
            snap_q        <= snap_d;
`else
            key_byte_q    <= key_byte_d;
`endif
        end
    end

    assign dio_o       = dio_o_q;
    assign dio_e       = dio_e_q;
    assign display_ram = display_ram_q;
    assign display_on  = on_q;
    assign brightness  = bright_q;
    assign ram_wr      = ram_wr_q;
    assign ram_wr_addr = ram_wr_addr_q;
    assign key_rd      = key_rd_q;

endmodule
